// File: rtl/fb_draw_if.sv
// Host command channel and framebuffer write port of the draw engine.
// The host drives the master side; the engine is the slave side.
interface fb_draw_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [8:0]  cmd_x;
   logic [7:0]  cmd_y;
   logic [8:0]  cmd_len;
   logic [23:0] cmd_color;
   logic        wr_en;
   logic [15:0] wr_adr;
   logic [23:0] wr_data;
   logic        busy;
   logic        cmd_err;

   modport master (
      output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, cmd_color,
      input  cmd_ready, wr_en, wr_adr, wr_data, busy, cmd_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, cmd_color,
      output cmd_ready, wr_en, wr_adr, wr_data, busy, cmd_err
   );
endinterface

// File: rtl/fb_draw.sv
// Framebuffer draw engine: turns plot/span/clear commands into
// one framebuffer RAM write per clock.
module fb_draw #(
   parameter int WIDTH  = 280,
   parameter int HEIGHT = 192
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   fb_draw_if.slave   bus
);

   localparam int NPIX = WIDTH * HEIGHT;

   localparam logic [1:0] OP_PLOT  = 2'b00;
   localparam logic [1:0] OP_HLINE = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_nx;
   logic        wr_en_q, wr_en_nx;
   logic [15:0] adr_q, adr_nx;
   logic [23:0] data_q, data_nx;
   logic        err_q, err_nx;
   logic [16:0] rem_q, rem_nx;

   logic        x_ok, y_ok, accept;
   logic [15:0] pix_adr;
   logic [16:0] avail, len17, span_n;

   assign accept  = bus.cmd_valid && (state == IDLE);
   assign x_ok    = int'(bus.cmd_x) < WIDTH;
   assign y_ok    = int'(bus.cmd_y) < HEIGHT;
   assign pix_adr = 16'(int'(bus.cmd_y) * WIDTH + int'(bus.cmd_x));
   assign avail   = 17'(WIDTH - int'(bus.cmd_x));
   assign len17   = {8'd0, bus.cmd_len};
   // Spans clip at the right edge instead of wrapping to the next row.
   assign span_n  = (len17 < avail) ? len17 : avail;

   // State and write-port registers; reset abandons any span in flight.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         wr_en_q <= 1'b0;
         adr_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         rem_q   <= '0;
      end else begin
         state   <= state_nx;
         wr_en_q <= wr_en_nx;
         adr_q   <= adr_nx;
         data_q  <= data_nx;
         err_q   <= err_nx;
         rem_q   <= rem_nx;
      end
   end

   // Command decode in IDLE, address stepping in RUN.
   always_comb begin
      state_nx = state;
      wr_en_nx = 1'b0;
      adr_nx   = adr_q;
      data_nx  = data_q;
      err_nx   = 1'b0;
      rem_nx   = rem_q;
      unique case (state)
         IDLE: begin
            if (accept) begin
               unique case (bus.cmd_op)
                  OP_PLOT: begin
                     if (x_ok && y_ok) begin
                        wr_en_nx = 1'b1;
                        adr_nx   = pix_adr;
                        data_nx  = bus.cmd_color;
                     end else begin
                        err_nx = 1'b1;
                     end
                  end
                  OP_HLINE: begin
                     if (x_ok && y_ok && bus.cmd_len != '0) begin
                        wr_en_nx = 1'b1;
                        adr_nx   = pix_adr;
                        data_nx  = bus.cmd_color;
                        rem_nx   = span_n;
                        state_nx = RUN;
                     end else begin
                        err_nx = 1'b1;
                     end
                  end
                  OP_CLEAR: begin
                     wr_en_nx = 1'b1;
                     adr_nx   = '0;
                     data_nx  = bus.cmd_color;
                     rem_nx   = 17'(NPIX);
                     state_nx = RUN;
                  end
                  OP_RSVD: begin
                     err_nx = 1'b1;
                  end
               endcase
            end
         end
         RUN: begin
            if (rem_q > 17'd1) begin
               wr_en_nx = 1'b1;
               adr_nx   = adr_q + 16'd1;
               rem_nx   = rem_q - 17'd1;
            end else begin
               rem_nx   = '0;
               state_nx = IDLE;
            end
         end
      endcase
   end

   assign bus.cmd_ready = (state == IDLE);
   assign bus.busy      = (state == RUN);
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_adr    = adr_q;
   assign bus.wr_data   = data_q;
   assign bus.cmd_err   = err_q;

endmodule

// File: tb/tb_fb_draw.sv
// Bench for fb_draw: directed vector table, randomized commands
// against a pixel-arithmetic model, plus reset and back-to-back sequences.
module tb_fb_draw;

   localparam int W = 280;
   localparam int H = 192;

   logic clk;
   logic rst_n;
   fb_draw_if bus ();

   fb_draw #(.WIDTH(W), .HEIGHT(H)) dut (
      .CLOCK_50 (clk),
      .reset    (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vecs = 0;
   int miss = 0;

   typedef struct {
      logic [1:0]  op;
      logic [8:0]  x;
      logic [7:0]  y;
      logic [8:0]  len;
      logic [23:0] col;
      int          n;
      int          start;
      bit          err;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected write count, start address and rejection from pixel geometry.
   function automatic void model(input logic [1:0] op, input int x,
                                 input int y, input int len,
                                 output int n, output int st, output bit err);
      n = 0; st = 0; err = 0;
      case (op)
         2'b00: if (x < W && y < H) begin n = 1; st = y * W + x; end
                else err = 1;
         2'b01: if (x < W && y < H && len != 0) begin
                   n = (len < W - x) ? len : W - x;
                   st = y * W + x;
                end else err = 1;
         2'b10: begin n = W * H; st = 0; end
         default: err = 1;
      endcase
   endfunction

   // Issue one command from a negedge and check every following cycle.
   task automatic do_cmd(input logic [1:0] op, input logic [8:0] x,
                         input logic [7:0] y, input logic [8:0] len,
                         input logic [23:0] col, input int en,
                         input int es, input bit ee);
      int g;
      bit span;
      g = 0;
      while (bus.cmd_ready !== 1'b1 && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_x     = x;
      bus.cmd_y     = y;
      bus.cmd_len   = len;
      bus.cmd_color = col;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_x     = 9'($urandom);
      bus.cmd_y     = 8'($urandom);
      bus.cmd_len   = 9'($urandom);
      bus.cmd_color = 24'($urandom);
      @(negedge clk);
      span = (op != 2'b00);
      if (en == 0) begin
         chk("err_pulse", 32'(bus.cmd_err), 32'(ee));
         chk("err_no_wr", 32'(bus.wr_en), 32'd0);
         chk("err_ready", 32'(bus.cmd_ready), 32'd1);
         @(negedge clk);
      end else begin
         for (int c = 0; c < en; c++) begin
            chk("wr_en", 32'(bus.wr_en), 32'd1);
            chk("wr_adr", 32'(bus.wr_adr), 32'(es + c));
            chk("wr_data", 32'(bus.wr_data), 32'(col));
            chk("no_err", 32'(bus.cmd_err), 32'd0);
            chk("busy", 32'(bus.busy), 32'(span));
            chk("ready_in_wr", 32'(bus.cmd_ready), 32'(!span));
            @(negedge clk);
         end
      end
      chk("idle_wr_en", 32'(bus.wr_en), 32'd0);
      chk("idle_err", 32'(bus.cmd_err), 32'd0);
      chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
      chk("idle_busy", 32'(bus.busy), 32'd0);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
      chk({tag, "_wr_adr"}, 32'(bus.wr_adr), 32'd0);
      chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
      chk({tag, "_err"}, 32'(bus.cmd_err), 32'd0);
      chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int n, st;
      bit er;
      logic [1:0] op;
      logic [8:0] rx, rl;
      logic [7:0] ry;
      logic [23:0] rc;

      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_x     = '0;
      bus.cmd_y     = '0;
      bus.cmd_len   = '0;
      bus.cmd_color = '0;
      #1;
      chk_reset_outs("por");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back plots: writes in consecutive cycles, ready held.
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_x     = 9'd0;
      bus.cmd_y     = 8'd0;
      bus.cmd_color = 24'hFF0000;
      @(posedge clk);
      @(negedge clk);
      chk("b2b_wr_en0", 32'(bus.wr_en), 32'd1);
      chk("b2b_adr0", 32'(bus.wr_adr), 32'd0);
      chk("b2b_data0", 32'(bus.wr_data), 32'hFF0000);
      chk("b2b_ready0", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_x     = 9'd279;
      bus.cmd_y     = 8'd191;
      bus.cmd_color = 24'h00FF00;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("b2b_wr_en1", 32'(bus.wr_en), 32'd1);
      chk("b2b_adr1", 32'(bus.wr_adr), 32'd53759);
      chk("b2b_data1", 32'(bus.wr_data), 32'h00FF00);
      chk("b2b_ready1", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      chk("b2b_done", 32'(bus.wr_en), 32'd0);
      chk("b2b_hold_adr", 32'(bus.wr_adr), 32'd53759);

      tbl.push_back('{2'b01, 9'd270, 8'd1, 9'd20, 24'h123456, 10, 550, 1'b0});
      tbl.push_back('{2'b00, 9'd280, 8'd0, 9'd0, 24'h111111, 0, 0, 1'b1});
      tbl.push_back('{2'b01, 9'd3, 8'd4, 9'd0, 24'h222222, 0, 0, 1'b1});
      tbl.push_back('{2'b01, 9'd3, 8'd192, 9'd5, 24'h333333, 0, 0, 1'b1});
      tbl.push_back('{2'b11, 9'd3, 8'd4, 9'd5, 24'h444444, 0, 0, 1'b1});
      tbl.push_back('{2'b00, 9'd5, 8'd2, 9'd0, 24'hABCDEF, 1, 565, 1'b0});
      tbl.push_back('{2'b01, 9'd0, 8'd0, 9'd300, 24'h0F0F0F, 280, 0, 1'b0});
      tbl.push_back('{2'b01, 9'd279, 8'd191, 9'd5, 24'h5A5A5A, 1, 53759, 1'b0});
      tbl.push_back('{2'b01, 9'd10, 8'd3, 9'd1, 24'h777777, 1, 850, 1'b0});
      tbl.push_back('{2'b10, 9'd99, 8'd99, 9'd99, 24'h000000, 53760, 0, 1'b0});
      foreach (tbl[i])
         do_cmd(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].len, tbl[i].col,
                tbl[i].n, tbl[i].start, tbl[i].err);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 2))
            0: op = 2'b00;
            1: op = 2'b01;
            default: op = 2'b11;
         endcase
         rx = 9'($urandom_range(0, 300));
         ry = 8'($urandom_range(0, 200));
         rl = 9'($urandom_range(0, 300));
         rc = 24'($urandom);
         model(op, int'(rx), int'(ry), int'(rl), n, st, er);
         do_cmd(op, rx, ry, rl, rc, n, st, er);
      end

      // Reset 100 cycles into a clear, then a plot after release.
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b10;
      bus.cmd_color = 24'hC0FFEE;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (100) @(posedge clk);
      #2;
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outs("mid_rst");
      @(negedge clk);
      chk_reset_outs("held_rst");
      rst_n = 1'b1;
      do_cmd(2'b00, 9'd5, 8'd2, 9'd0, 24'hABCDEF, 1, 565, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
